falafel_alloc_req_fifo: RTL and testbench
=========================================

// Module: falafel_alloc_req_fifo
// PURPOSE
//  Buffers allocation requests (size + message id) between the input arbiter and the allocator core.
//  The arbiter drives a write/full port; the allocator core drains a first-word-fall-through valid/ready port.
//  Provides occupancy, almost-full and a sticky overflow flag for debug and config-reg readback.
// PARAMETERS
//  DEPTH           8         entries; power of two, >= 2
//  AFULL_THRESH    DEPTH-2   almost_full_o asserts when count_o >= AFULL_THRESH; range 1..DEPTH
//  CNT_W           $clog2(DEPTH+1)  localparam, occupancy width
// PORTS
//  clk_i           in   1            clock
//  rst_ni          in   1            asynchronous, active-low reset
//  write_i         in   1            push din_* this cycle
//  din_size_i      in   word_t       requested size
//  din_id_i        in   MSG_ID_SIZE  request message id
//  full_o          out  1            no free entry; write_i must not be asserted
//  almost_full_o   out  1            count_o >= AFULL_THRESH
//  dout_val_o      out  1            head entry valid
//  dout_rdy_i      in   1            consumer accepts head
//  dout_size_o     out  word_t       head size (0 when !dout_val_o)
//  dout_id_o       out  MSG_ID_SIZE  head id (0 when !dout_val_o)
//  count_o         out  CNT_W        entries stored
//  overflow_err_o  out  1            sticky: write_i seen while full_o
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers = 0, count_o = 0, full_o = 0, almost_full_o = 0,
//    dout_val_o = 0, dout_* = 0, overflow_err_o = 0. Storage contents are not reset.
//  - Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    - empty: pointers equal.
//    - full: index bits equal and wrap bits differ.
//  - full_o, almost_full_o, count_o and dout_val_o are registered-state decodes only.
//    None of them depends combinationally on write_i or dout_rdy_i.
//  - Push: write_i && !full_o. Stores {din_size_i, din_id_i} at wr_ptr; wr_ptr++ at the next edge.
//  - Pop: dout_val_o && dout_rdy_i. rd_ptr++ at the next edge.
//  - FWFT head: dout_* = mem[rd_ptr] while not empty. Write-to-dout latency is 1 cycle (no same-cycle bypass).
//  - Push and pop in the same cycle:
//    - both take effect; count_o is unchanged.
//    - when empty, only the push is legal (dout_val_o = 0), so count_o goes 0 -> 1.
//  - write_i while full_o: data is dropped and no pointer moves.
//    overflow_err_o sets at the next edge and clears only on reset.
//    A pop in the same cycle still occurs; the write is still dropped because full_o is state-based.
//  - dout_rdy_i while empty: ignored.
//  - count_o = wr_ptr - rd_ptr, modulo 2^(ptr width).
//  - Reset mid-operation discards all entries immediately; outputs go to their reset values.
//  - Assertions (sim only):
//    - no push when full;
//    - count_o <= DEPTH;
//    - dout_* stable while dout_val_o && !dout_rdy_i.
// STRUCTURE
//  - falafel_pkg holds:
//    - alloc_entry_t {word_t size; logic [MSG_ID_SIZE-1:0] id};
//    - ALLOC_FIFO_DEPTH default (8), used by the top-level instantiation.
//  - Storage is an alloc_entry_t array indexed by the pointer index bits.
//  - One natural sub-module, falafel_fifo_ptrs. It owns the wr/rd pointers and produces:
//    empty, full, count, almost_full.
//    The free-request FIFO reuses it; data storage stays in this module.
// TESTING
//  1. Reset, then idle: full_o = 0, dout_val_o = 0, count_o = 0, overflow_err_o = 0.
//  2. Push size = 0x40, id = 3; no pop.
//     -> dout_val_o = 1 one cycle later, dout_size_o = 0x40, dout_id_o = 3, count_o = 1.
//  3. DEPTH = 8: push ids 0..7 with dout_rdy_i = 0.
//     -> full_o = 1 after 8th push; almost_full_o = 1 from count 6.
//     Then drain: ids pop in order 0..7, after which dout_val_o = 0.
//  4. Push and pop every cycle for 20 cycles (pointers wrap twice).
//     -> count_o stays 1, order preserved, no overflow.
//  5. Fill to 8, assert write_i (id = 9) with dout_rdy_i = 1.
//     -> id 0 pops, id 9 is dropped, count_o = 7, overflow_err_o = 1 (sticky).
//  6. Reset pulse with count_o = 5.
//     -> count_o = 0, dout_val_o = 0 immediately.
//     Next push (id = 2) is the next output.

Source files
------------

// File: rtl/falafel_pkg.sv
// Shared types and defaults for the falafel allocator request/free paths.
package falafel_pkg;

    localparam int unsigned WORD_SIZE        = 32;
    localparam int unsigned MSG_ID_SIZE      = 8;
    localparam int unsigned ALLOC_FIFO_DEPTH = 8;

    typedef logic [WORD_SIZE-1:0] word_t;

    // One buffered allocation request.
    typedef struct packed {
        word_t                  size;
        logic [MSG_ID_SIZE-1:0] id;
    } alloc_entry_t;

endpackage

// File: rtl/falafel_alloc_req_fifo_chk.sv
// Simulation-only protocol checks for the allocation request FIFO.
module falafel_alloc_req_fifo_chk #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DATA_W = 40
) (
    input logic              clk,
    input logic              rst_n,
    input logic              push,
    input logic              full,
    input logic [CNT_W-1:0]  count,
    input logic              dout_val,
    input logic              dout_rdy,
    input logic [DATA_W-1:0] dout
);

    // A qualified push never lands on a full buffer.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

    // Occupancy never exceeds capacity.
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));

    // A stalled head holds its value.
    a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (dout_val && !dout_rdy) |=> $stable(dout));

endmodule

// File: rtl/falafel_fifo_ptrs.sv
// Wrap-bit read/write pointer pair with registered empty/full/count/almost-full.
// Flags are computed from the next-state pointers and registered, so they
// never depend combinationally on the push/pop qualifiers of the current cycle.
// The caller must qualify push with !full and pop with !empty.
module falafel_fifo_ptrs #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = DEPTH - 2,
    localparam int unsigned IDX_W       = $clog2(DEPTH),
    localparam int unsigned PTR_W       = IDX_W + 1,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_idx_nxt,
    output logic             empty_nxt,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_nxt_s;
    logic             empty_nxt_s;
    logic             afull_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             afull_r;
    logic [CNT_W-1:0] count_r;

    // Next-state pointers and the flag decodes of those next pointers.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[IDX_W-1:0] == rd_ptr_nxt_s[IDX_W-1:0]) &&
                      (wr_ptr_nxt_s[IDX_W] != rd_ptr_nxt_s[IDX_W]);
        count_nxt_s = CNT_W'(wr_ptr_nxt_s - rd_ptr_nxt_s);
        afull_nxt_s = (count_nxt_s >= CNT_W'(AFULL_THRESH));
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            empty_r  <= empty_nxt_s;
            full_r   <= full_nxt_s;
            afull_r  <= afull_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    assign wr_idx      = wr_ptr_r[IDX_W-1:0];
    assign rd_idx_nxt  = rd_ptr_nxt_s[IDX_W-1:0];
    assign empty_nxt   = empty_nxt_s;
    assign empty       = empty_r;
    assign full        = full_r;
    assign almost_full = afull_r;
    assign count       = count_r;

endmodule

// File: rtl/falafel_alloc_req_fifo.sv
// Allocation request FIFO between the input arbiter (write/full) and the
// allocator core (first-word-fall-through valid/ready). Head data is held in
// a register loaded from the next-state head, giving one cycle write-to-dout
// latency and zeroed outputs while empty.
module falafel_alloc_req_fifo
    import falafel_pkg::*;
#(
    parameter int unsigned DEPTH        = ALLOC_FIFO_DEPTH,
    parameter int unsigned AFULL_THRESH = DEPTH - 2,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W       = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   write_i,
    input  word_t                  din_size_i,
    input  logic [MSG_ID_SIZE-1:0] din_id_i,
    output logic                   full_o,
    output logic                   almost_full_o,
    output logic                   dout_val_o,
    input  logic                   dout_rdy_i,
    output word_t                  dout_size_o,
    output logic [MSG_ID_SIZE-1:0] dout_id_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   overflow_err_o
);

    alloc_entry_t     mem_r [DEPTH];
    alloc_entry_t     din_entry_s;
    alloc_entry_t     head_nxt_s;
    alloc_entry_t     head_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             empty_nxt_s;
    logic             afull_s;
    logic [CNT_W-1:0] count_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_nxt_s;
    logic             overflow_r;

    assign din_entry_s = '{size: din_size_i, id: din_id_i};
    // Both qualifiers use registered state only, so a write while full is dropped
    // even if a pop frees a slot in the same cycle.
    assign push_s      = write_i && !full_s;
    assign pop_s       = !empty_s && dout_rdy_i;

    falafel_fifo_ptrs #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ptrs (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .push        (push_s),
        .pop         (pop_s),
        .wr_idx      (wr_idx_s),
        .rd_idx_nxt  (rd_idx_nxt_s),
        .empty_nxt   (empty_nxt_s),
        .empty       (empty_s),
        .full        (full_s),
        .almost_full (afull_s),
        .count       (count_s)
    );

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_idx_s] <= din_entry_s;
        end
    end

    // Head value after this edge: zero when empty, the incoming entry when it
    // becomes the head, otherwise the stored entry at the next read index.
    always_comb begin
        head_nxt_s = '0;
        if (empty_nxt_s) begin
            head_nxt_s = '0;
        end else if (push_s && (wr_idx_s == rd_idx_nxt_s)) begin
            head_nxt_s = din_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_idx_nxt_s];
        end
    end

    // Registered head data and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            head_r <= head_nxt_s;
            if (write_i && full_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign full_o         = full_s;
    assign almost_full_o  = afull_s;
    assign dout_val_o     = !empty_s;
    assign dout_size_o    = head_r.size;
    assign dout_id_o      = head_r.id;
    assign count_o        = count_s;
    assign overflow_err_o = overflow_r;

    falafel_alloc_req_fifo_chk #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DATA_W ($bits(alloc_entry_t))
    ) u_chk (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (push_s),
        .full     (full_s),
        .count    (count_s),
        .dout_val (dout_val_o),
        .dout_rdy (dout_rdy_i),
        .dout     (head_r)
    );

endmodule

// File: tb/tb_falafel_alloc_req_fifo.sv
// Directed plus randomized bench for falafel_alloc_req_fifo, checked against a
// queue-based reference model of the FIFO behaviour.
module tb_falafel_alloc_req_fifo;
    import falafel_pkg::*;

    localparam int unsigned DEPTH = ALLOC_FIFO_DEPTH;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   write_i = 1'b0;
    word_t                  din_size_i = '0;
    logic [MSG_ID_SIZE-1:0] din_id_i = '0;
    logic                   full_o;
    logic                   almost_full_o;
    logic                   dout_val_o;
    logic                   dout_rdy_i = 1'b0;
    word_t                  dout_size_o;
    logic [MSG_ID_SIZE-1:0] dout_id_o;
    logic [CNT_W-1:0]       count_o;
    logic                   overflow_err_o;

    int n_cmp = 0;
    int n_err = 0;

    alloc_entry_t q[$];
    bit           ovf_m = 1'b0;

    always #5 clk = ~clk;

    falafel_alloc_req_fifo dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .write_i        (write_i),
        .din_size_i     (din_size_i),
        .din_id_i       (din_id_i),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .dout_val_o     (dout_val_o),
        .dout_rdy_i     (dout_rdy_i),
        .dout_size_o    (dout_size_o),
        .dout_id_o      (dout_id_o),
        .count_o        (count_o),
        .overflow_err_o (overflow_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".count"}, 64'(count_o), 64'(n));
        check({tag, ".full"}, 64'(full_o), 64'(n == DEPTH));
        check({tag, ".afull"}, 64'(almost_full_o), 64'(n >= AF));
        check({tag, ".val"}, 64'(dout_val_o), 64'(n != 0));
        check({tag, ".size"}, 64'(dout_size_o), (n != 0) ? 64'(q[0].size) : 64'd0);
        check({tag, ".id"}, 64'(dout_id_o), (n != 0) ? 64'(q[0].id) : 64'd0);
        check({tag, ".ovf"}, 64'(overflow_err_o), 64'(ovf_m));
    endtask

    // One clock: drive inputs, apply the FIFO rules to the model, check after the edge.
    task automatic step(input string tag, input logic wr, input word_t sz,
                        input logic [MSG_ID_SIZE-1:0] id, input logic rdy);
        bit was_full;
        bit was_val;
        alloc_entry_t e;
        was_full   = (q.size() == DEPTH);
        was_val    = (q.size() != 0);
        write_i    = wr;
        din_size_i = sz;
        din_id_i   = id;
        dout_rdy_i = rdy;
        @(posedge clk);
        if (rdy && was_val) void'(q.pop_front());
        if (wr && was_full) ovf_m = 1'b1;
        if (wr && !was_full) begin
            e.size = sz;
            e.id   = id;
            q.push_back(e);
        end
        #1;
        write_i    = 1'b0;
        dout_rdy_i = 1'b0;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            if (q.size() != 0) step(tag, 1'b0, '0, '0, 1'b1);
        end
    endtask

    initial begin
        int unsigned p_wr;
        int unsigned p_rd;

        // 1: reset then idle
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("t1.count", 64'(count_o), 64'd0);
        check("t1.full", 64'(full_o), 64'd0);
        check("t1.val", 64'(dout_val_o), 64'd0);
        check("t1.ovf", 64'(overflow_err_o), 64'd0);
        step("t1.idle", 1'b0, '0, '0, 1'b0);

        // 2: single push, visible one cycle later
        step("t2.push", 1'b1, 32'h40, 8'd3, 1'b0);
        check("t2.val", 64'(dout_val_o), 64'd1);
        check("t2.size", 64'(dout_size_o), 64'h40);
        check("t2.id", 64'(dout_id_o), 64'd3);
        check("t2.count", 64'(count_o), 64'd1);
        drain("t2.drain");

        // 3: fill with ids 0..7, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step("t3.fill", 1'b1, $urandom, MSG_ID_SIZE'(i), 1'b0);
            check("t3.full", 64'(full_o), 64'(i == DEPTH - 1));
            check("t3.afull", 64'(almost_full_o), 64'(i + 1 >= 6));
        end
        for (int i = 0; i < DEPTH; i++) begin
            check("t3.order", 64'(dout_id_o), 64'(i));
            step("t3.drain", 1'b0, '0, '0, 1'b1);
        end
        check("t3.empty", 64'(dout_val_o), 64'd0);

        // 4: simultaneous push/pop for 20 cycles
        step("t4.prime", 1'b1, $urandom, 8'd100, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("t4.pp", 1'b1, $urandom, MSG_ID_SIZE'(101 + i), 1'b1);
            check("t4.count", 64'(count_o), 64'd1);
            check("t4.id", 64'(dout_id_o), 64'(101 + i));
        end
        check("t4.ovf", 64'(overflow_err_o), 64'd0);
        drain("t4.drain");

        // 5: write while full with concurrent pop
        for (int i = 0; i < DEPTH; i++) step("t5.fill", 1'b1, $urandom, MSG_ID_SIZE'(i), 1'b0);
        step("t5.ovf", 1'b1, 32'h99, 8'd9, 1'b1);
        check("t5.count", 64'(count_o), 64'd7);
        check("t5.ovf_set", 64'(overflow_err_o), 64'd1);
        check("t5.head", 64'(dout_id_o), 64'd1);
        for (int i = 1; i < DEPTH; i++) begin
            check("t5.order", 64'(dout_id_o), 64'(i));
            step("t5.drain", 1'b0, '0, '0, 1'b1);
        end
        step("t5.idle", 1'b0, '0, '0, 1'b0);
        check("t5.sticky", 64'(overflow_err_o), 64'd1);

        // 6: reset with five entries stored
        for (int i = 0; i < 5; i++) step("t6.fill", 1'b1, $urandom, MSG_ID_SIZE'(20 + i), 1'b0);
        rst_ni = 1'b0;
        #1;
        q.delete();
        ovf_m = 1'b0;
        check("t6.count", 64'(count_o), 64'd0);
        check("t6.val", 64'(dout_val_o), 64'd0);
        check_all("t6.rst");
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        step("t6.push", 1'b1, 32'h123, 8'd2, 1'b0);
        check("t6.next", 64'(dout_id_o), 64'd2);
        drain("t6.drain");

        // randomized traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            p_wr = (i < 200) ? 70 : 30;
            p_rd = (i < 200) ? 35 : 75;
            step("rnd", 1'($urandom_range(0, 99) < p_wr), $urandom,
                 MSG_ID_SIZE'($urandom), 1'($urandom_range(0, 99) < p_rd));
        end
        drain("rnd.drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
